// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send, then shifts
// one command byte plus odd parity out on device-generated clock falls and checks the ack.
module ps2_host_tx #(
    parameter int sysclk_frequency = 1000,
    parameter int inhibit_us       = 100,
    parameter int timeout_us       = 15000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] fsm_state
);

    localparam int INHIBIT_CYCLES = sysclk_frequency * inhibit_us / 10;
    localparam int TIMEOUT_CYCLES = sysclk_frequency * timeout_us / 10;
    localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_RTS      = 3'd2,
        S_SHIFT    = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t             state;
    logic [8:0]         shreg;
    logic [3:0]         bitcnt;
    logic [INH_W-1:0]   inh_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic [1:0]         clk_sync, dat_sync;
    logic [3:0]         clk_hist, dat_hist;
    logic               clk_filt, dat_filt, clk_filt_q;
    logic               clk_fall;
    logic               timed_state;
    logic               timed_out;

    // Majority of four with hysteresis: a 2/2 split keeps the previous value.
    function automatic logic majority(input logic [3:0] h, input logic cur);
        logic [2:0] n;
        n = 3'(h[0]) + 3'(h[1]) + 3'(h[2]) + 3'(h[3]);
        if (n >= 3'd3)
            return 1'b1;
        else if (n <= 3'd1)
            return 1'b0;
        else
            return cur;
    endfunction

    // Idle bus is high, so the input pipeline resets to 1 to avoid a phantom fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_hist   <= 4'hF;
            dat_hist   <= 4'hF;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            dat_sync   <= {dat_sync[0], ps2_dat_in};
            clk_hist   <= {clk_hist[2:0], clk_sync[1]};
            dat_hist   <= {dat_hist[2:0], dat_sync[1]};
            clk_filt   <= majority(clk_hist, clk_filt);
            dat_filt   <= majority(dat_hist, dat_filt);
            clk_filt_q <= clk_filt;
        end
    end

    assign clk_fall    = clk_filt_q & ~clk_filt;
    assign timed_state = (state == S_RTS) || (state == S_SHIFT) ||
                         (state == S_ACK) || (state == S_WAITIDLE);
    // ERROR costs one more cycle before the pulse, so trip one count early to land
    // tx_error exactly timeout_cycles after entering RTS.
    assign timed_out   = timed_state && (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));
    assign fsm_state   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timed_state)
                to_cnt <= to_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_req && !tx_busy) begin
                        shreg      <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_busy    <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b1;
                        to_cnt     <= '0;
                        state      <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        shreg      <= {1'b0, shreg[8:1]};
                        bitcnt     <= 4'd1;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (clk_fall) begin
                        if (bitcnt == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= S_ACK;
                        end else begin
                            ps2_dat_oe <= ~shreg[0];
                            shreg      <= {1'b0, shreg[8:1]};
                            bitcnt     <= bitcnt + 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (clk_fall)
                        state <= dat_filt ? S_ERROR : S_WAITIDLE;
                end
                S_WAITIDLE: begin
                    if (clk_sync[1] && dat_sync[1]) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_error   <= 1'b1;
                    tx_busy    <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_busy    <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase

            // Timeout overrides whatever the bit logic decided this cycle.
            if (timed_out) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                state      <= S_ERROR;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus model with a clocking PS/2 device, a frame
// scoreboard checked by the device and a done/error scoreboard checked by a monitor.
module tb_ps2_host_tx;

    // 1 MHz system clock: inhibit = 100 cycles, timeout = 3000 cycles.
    localparam int SYS_FREQ = 10;
    localparam int INH_US   = 100;
    localparam int TO_US    = 3000;
    localparam int INH_CYC  = 100;
    localparam int TO_CYC   = 3000;
    localparam int HALF     = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic [2:0] fsm_state;

    int checks = 0;
    int fails  = 0;
    logic [9:0] exp_frame_q[$];
    logic [1:0] exp_resp_q[$];
    logic [1:0] resp_e;
    int         inh_len = 0;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .sysclk_frequency(SYS_FREQ),
        .inhibit_us      (INH_US),
        .timeout_us      (TO_US)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every done/error pulse must match the next expected response.
    always @(negedge clk) begin
        if (reset_n && (tx_done || tx_error)) begin
            if (exp_resp_q.size() == 0) begin
                check("unexpected_pulse", {30'b0, tx_error, tx_done}, 32'h0);
            end else begin
                resp_e = exp_resp_q.pop_front();
                check("resp", {30'b0, tx_error, tx_done}, {30'b0, resp_e});
            end
            check("oe_at_resp", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'h0);
            check("busy_at_resp", {31'b0, tx_busy}, 32'h0);
        end
    end

    // Clock-inhibit length monitor.
    always @(negedge clk) begin
        if (!reset_n) begin
            inh_len = 0;
        end else if (ps2_clk_oe) begin
            inh_len++;
        end else if (inh_len != 0) begin
            check("inhibit_len_ge", {31'b0, inh_len >= INH_CYC}, 32'h1);
            inh_len = 0;
        end
    end

    // mode: 0 ack, 1 no ack, 2 never clock. abort_bit: stop with clock held low after that fall.
    task automatic dev_xfer(input int mode, input int abort_bit);
        int         n = 0;
        logic [9:0] got = '0;
        logic [9:0] ef;
        while (!(ps2_clk_in && !ps2_dat_in) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", {30'b0, ps2_clk_in, ps2_dat_in}, 32'h2);
        if (n >= 2000 || mode == 2) return;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_dat = (mode == 0) ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            if (i == abort_bit) return;
            repeat (HALF) @(negedge clk);
            if (i < 10) got[i] = ps2_dat_in;
            dev_clk = 1'b1;
            if (i == 10) dev_dat = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        ef = (exp_frame_q.size() != 0) ? exp_frame_q.pop_front() : 10'bx;
        check("frame", {22'b0, got}, {22'b0, ef});
    endtask

    task automatic issue(input logic [7:0] d, input logic has_frame, input logic [9:0] frame,
                         input logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tx_data = d;
        tx_req  = 1'b1;
        if (has_frame) exp_frame_q.push_back(frame);
        if (resp != 2'b00) exp_resp_q.push_back(resp);
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'b0, tx_busy}, 32'h0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'h0);
        check("rst_busy", {31'b0, tx_busy}, 32'h0);
        check("rst_pulses", {30'b0, tx_done, tx_error}, 32'h0);
        check("rst_state", {29'b0, fsm_state}, 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        issue(8'hED, 1'b1, 10'h3ED, 2'b01);
        dev_xfer(0, 99);
        wait_idle();

        // parity boundaries
        issue(8'h00, 1'b1, 10'h300, 2'b01);
        dev_xfer(0, 99);
        wait_idle();
        issue(8'h01, 1'b1, 10'h201, 2'b01);
        dev_xfer(0, 99);
        wait_idle();

        // no ack at fall 11
        issue(8'hF4, 1'b1, 10'h2F4, 2'b10);
        dev_xfer(1, 99);
        wait_idle();

        // silent device: error exactly timeout cycles after RTS entry
        issue(8'h55, 1'b0, 10'h000, 2'b10);
        dev_xfer(2, 99);
        begin
            int n = 0;
            while (!tx_error && n < TO_CYC + 200) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, TO_CYC);
            check("timeout_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'h0);
        end
        wait_idle();

        // reset during bit 4 with device clock held low
        issue(8'h3C, 1'b0, 10'h000, 2'b00);
        dev_xfer(0, 4);
        repeat (10) @(negedge clk);
        check("mid_busy", {31'b0, tx_busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'h0);
        check("mid_rst_busy", {31'b0, tx_busy}, 32'h0);
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(8'hFF, 1'b1, 10'h3FF, 2'b01);
        dev_xfer(0, 99);
        wait_idle();

        // tx_req held high, data changed mid-transfer, back-to-back second transaction
        @(negedge clk);
        tx_data = 8'hED;
        tx_req  = 1'b1;
        exp_frame_q.push_back(10'h3ED);
        exp_resp_q.push_back(2'b01);
        exp_frame_q.push_back(10'h3AA);
        exp_resp_q.push_back(2'b01);
        fork
            dev_xfer(0, 99);
            begin
                repeat (400) @(negedge clk);
                tx_data = 8'hAA;
            end
            begin
                int n = 0;
                while (!tx_done && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                check("first_done", {31'b0, tx_done}, 32'h1);
                @(negedge clk);
                check("reaccept_busy", {31'b0, tx_busy}, 32'h1);
            end
        join
        tx_req = 1'b0;
        dev_xfer(0, 99);
        wait_idle();
        repeat (50) @(negedge clk);
        check("no_third_txn", {31'b0, tx_busy}, 32'h0);

        check("queues_empty", exp_frame_q.size() + exp_resp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, checks %0d failures %0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
